// File: rtl/nios2_debug_vjtag_scan_master.sv
// Virtual-JTAG scan master: turns one (IR, DR, length) command into a full
// UIR/CDR/SDR/E1DR/RTI sequence on vji_* and returns the captured tdo bits.
module nios2_debug_vjtag_scan_master #(
    parameter int HALF_DIV = 2,
    parameter int DR_W     = 38,
    parameter int IR_W     = 2
) (
    input  logic            clk,
    input  logic            reset,
    // Handshakes: a transfer happens on a rising clk edge where valid && ready.
    // valid never waits for ready; once raised, rsp_valid and rsp_data hold until taken.
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic [DR_W-1:0] cmd_data,
    input  logic [5:0]      cmd_len,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DR_W-1:0] rsp_data,
    output logic [IR_W-1:0] rsp_ir,
    output logic            vji_tck,
    output logic            vji_tdi,
    input  logic            vji_tdo,
    output logic [IR_W-1:0] vji_ir_in,
    input  logic [IR_W-1:0] vji_ir_out,
    output logic            vji_uir,
    output logic            vji_cdr,
    output logic            vji_sdr,
    output logic            vji_e1dr,
    output logic            vji_rti,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_E1DR = 3'd4,
        S_RTI  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam int            HC_W   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(HALF_DIV - 1);

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hc_q, hc_d;
    logic              tck_q, tck_d;
    logic              tdi_q, tdi_d;
    logic              uir_q, uir_d;
    logic              cdr_q, cdr_d;
    logic              sdr_q, sdr_d;
    logic              e1dr_q, e1dr_d;
    logic              rti_q, rti_d;
    logic [IR_W-1:0]   ir_in_q, ir_in_d;
    logic [DR_W-1:0]   tx_q, tx_d;
    logic [DR_W-1:0]   rx_q, rx_d;
    logic [5:0]        len_q, len_d;
    logic [5:0]        bit_q, bit_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DR_W-1:0]   rsp_data_q, rsp_data_d;
    logic [IR_W-1:0]   rsp_ir_q, rsp_ir_d;

    logic              tick;
    logic              rise;
    logic              fall;
    logic [5:0]        len_clamp;
    logic [5:0]        rsp_shift;

    assign cmd_ready = (state_q == S_IDLE) && !reset;
    assign tick      = (hc_q == HC_MAX);
    assign rise      = tick && !tck_q;
    assign fall      = tick && tck_q;
    assign len_clamp = (cmd_len == 6'd0 || cmd_len > 6'(DR_W)) ? 6'(DR_W) : cmd_len;
    // Captured bits sit at the top of rx; slide them down to bit 0.
    assign rsp_shift = 6'(DR_W) - len_q;

    always_comb begin
        state_d     = state_q;
        hc_d        = hc_q;
        tck_d       = tck_q;
        tdi_d       = tdi_q;
        uir_d       = uir_q;
        cdr_d       = cdr_q;
        sdr_d       = sdr_q;
        e1dr_d      = e1dr_q;
        rti_d       = rti_q;
        ir_in_d     = ir_in_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        len_d       = len_q;
        bit_d       = bit_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_ir_d    = rsp_ir_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = S_UIR;
                    hc_d    = '0;
                    tck_d   = 1'b0;
                    tdi_d   = 1'b0;
                    uir_d   = 1'b1;
                    ir_in_d = cmd_ir;
                    tx_d    = cmd_data;
                    rx_d    = '0;
                    len_d   = len_clamp;
                    bit_d   = len_clamp;
                end
            end

            S_UIR, S_CDR, S_SDR, S_E1DR, S_RTI: begin
                if (tick) begin
                    hc_d  = '0;
                    tck_d = ~tck_q;
                end else begin
                    hc_d = hc_q + HC_W'(1);
                end

                if (rise && state_q == S_CDR) begin
                    rsp_ir_d = vji_ir_out;
                end
                if (rise && state_q == S_SDR) begin
                    rx_d  = {vji_tdo, rx_q[DR_W-1:1]};
                    bit_d = bit_q - 6'd1;
                end

                // Each falling tck edge closes a phase; SDR repeats until all bits are in.
                if (fall) begin
                    if (state_q == S_UIR) begin
                        state_d = S_CDR;
                        uir_d   = 1'b0;
                        cdr_d   = 1'b1;
                    end else if (state_q == S_CDR) begin
                        state_d = S_SDR;
                        cdr_d   = 1'b0;
                        sdr_d   = 1'b1;
                        tdi_d   = tx_q[0];
                    end else if (state_q == S_SDR) begin
                        if (bit_q == 6'd0) begin
                            state_d = S_E1DR;
                            sdr_d   = 1'b0;
                            e1dr_d  = 1'b1;
                            tdi_d   = 1'b0;
                        end else begin
                            tx_d  = tx_q >> 1;
                            tdi_d = tx_q[1];
                        end
                    end else if (state_q == S_E1DR) begin
                        state_d = S_RTI;
                        e1dr_d  = 1'b0;
                        rti_d   = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        rti_d   = 1'b0;
                    end
                end
            end

            S_DONE: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q >> rsp_shift;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hc_q        <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            e1dr_q      <= 1'b0;
            rti_q       <= 1'b0;
            ir_in_q     <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            len_q       <= '0;
            bit_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ir_q    <= '0;
        end else begin
            state_q     <= state_d;
            hc_q        <= hc_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            uir_q       <= uir_d;
            cdr_q       <= cdr_d;
            sdr_q       <= sdr_d;
            e1dr_q      <= e1dr_d;
            rti_q       <= rti_d;
            ir_in_q     <= ir_in_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            len_q       <= len_d;
            bit_q       <= bit_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ir_q    <= rsp_ir_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ir    = rsp_ir_q;
    assign vji_tck   = tck_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_in_q;
    assign vji_uir   = uir_q;
    assign vji_cdr   = cdr_q;
    assign vji_sdr   = sdr_q;
    assign vji_e1dr  = e1dr_q;
    assign vji_rti   = rti_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nios2_debug_vjtag_scan_master.sv
// Bench for the virtual-JTAG scan master: a small slave model drives tdo/ir_out,
// and a scoreboard checks each response against a bit-level reference model.
module tb_nios2_debug_vjtag_scan_master;

    localparam int HALF_DIV = 2;
    localparam int DR_W     = 38;
    localparam int IR_W     = 2;

    logic            clk;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_data;
    logic [5:0]      cmd_len;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DR_W-1:0] rsp_data;
    logic [IR_W-1:0] rsp_ir;
    logic            vji_tck;
    logic            vji_tdi;
    logic            vji_tdo;
    logic [IR_W-1:0] vji_ir_in;
    logic [IR_W-1:0] vji_ir_out;
    logic            vji_uir;
    logic            vji_cdr;
    logic            vji_sdr;
    logic            vji_e1dr;
    logic            vji_rti;
    logic [2:0]      dbg_state;

    nios2_debug_vjtag_scan_master #(
        .HALF_DIV(HALF_DIV), .DR_W(DR_W), .IR_W(IR_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
        .cmd_data(cmd_data), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir(rsp_ir),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
        .vji_e1dr(vji_e1dr), .vji_rti(vji_rti), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_count = 0;
    int hs_cyc = 0;
    int last_acc_cyc = 0;
    int viol = 0;
    logic hold_low = 1'b0;

    // Slave model: tdo source selected per command (0 loopback, 1 ones, 2 random vector).
    int          cur_mode = 0;
    logic [63:0] tdo_vec = '0;
    int          sdr_idx = 0;
    int          sdr_rises = 0;
    assign vji_tdo = (cur_mode == 0) ? vji_tdi : (cur_mode == 1) ? 1'b1 : tdo_vec[sdr_idx[5:0]];

    logic [DR_W-1:0] exp_data_q[$];
    logic [DR_W-1:0] exp_tx_q[$];
    logic [IR_W-1:0] exp_irout_q[$];
    logic [IR_W-1:0] exp_cmdir_q[$];
    int              exp_len_q[$];
    int              exp_acc_q[$];
    logic [4:0]      obs_code_q[$];
    logic            obs_tdi_q[$];
    logic [IR_W-1:0] obs_irin_q[$];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int clamp_len(input logic [5:0] len);
        return (len == 0 || len > DR_W) ? DR_W : int'(len);
    endfunction

    // Reference: response is the first L tdo bits the slave presented, bit 0 first.
    function automatic logic [DR_W-1:0] model_rsp(input int mode, input logic [DR_W-1:0] data,
                                                   input logic [63:0] tv, input int len);
        logic [63:0] mask;
        logic [63:0] src;
        mask = (64'd1 << len) - 64'd1;
        src  = (mode == 0) ? 64'(data) : (mode == 1) ? {64{1'b1}} : tv;
        return DR_W'(src & mask);
    endfunction

    function automatic logic [63:0] all_outputs();
        return 64'({cmd_ready, rsp_valid, rsp_data, rsp_ir, vji_tck, vji_tdi, vji_ir_in,
                    vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti, dbg_state});
    endfunction

    // driver tasks
    task automatic send(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] data,
                        input logic [5:0] len, input int mode, input logic [63:0] tv,
                        input logic [IR_W-1:0] iro);
        int n;
        int L;
        L = clamp_len(len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_len   = len;
        n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            cur_mode   = mode;
            tdo_vec    = tv;
            vji_ir_out = iro;
            sdr_idx    = 0;
            sdr_rises  = 0;
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_data  = DR_W'({$urandom, $urandom});
            cmd_ir    = IR_W'($urandom);
            cmd_len   = 6'($urandom);
            last_acc_cyc = cyc;
            obs_code_q.delete();
            obs_tdi_q.delete();
            obs_irin_q.delete();
            exp_data_q.push_back(model_rsp(mode, data, tv, L));
            exp_tx_q.push_back(data);
            exp_irout_q.push_back(iro);
            exp_cmdir_q.push_back(ir);
            exp_len_q.push_back(L);
            exp_acc_q.push_back(cyc);
        end
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_count < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (rsp_count < target) check("rsp_timeout", 64'(rsp_count), 64'(target));
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // tck-domain observer: what the slave sees at each rising tck
    initial forever begin
        @(posedge vji_tck);
        #1;
        obs_code_q.push_back({vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti});
        if (vji_uir) obs_irin_q.push_back(vji_ir_in);
        if (vji_sdr) begin
            obs_tdi_q.push_back(vji_tdi);
            sdr_rises++;
            sdr_idx++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!$onehot0({vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti})) viol++;
        if (vji_tck && (cmd_ready || rsp_valid)) viol++;
    end

    // scoreboard monitor
    initial begin : monitor
        logic            pending;
        logic            stable_ok;
        logic            seq_ok;
        logic [DR_W-1:0] cur;
        logic [DR_W-1:0] tx;
        logic [63:0]     act_tdi;
        logic [4:0]      code;
        int              L;
        pending = 1'b0;
        stable_ok = 1'b1;
        cur = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pending = 1'b0;
            end else begin
                if (rsp_valid && !pending) begin
                    pending = 1'b1;
                    stable_ok = 1'b1;
                    cur = rsp_data;
                    if (exp_data_q.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        L   = exp_len_q.pop_front();
                        cur = exp_data_q.pop_front();
                        tx  = exp_tx_q.pop_front();
                        check("rsp_data", 64'(rsp_data), 64'(cur));
                        check("rsp_ir", 64'(rsp_ir), 64'(exp_irout_q.pop_front()));
                        check("latency", 64'(cyc - exp_acc_q.pop_front()),
                              64'(1 + (L + 4) * 2 * HALF_DIV));
                        check("tck_periods", 64'(obs_code_q.size()), 64'(L + 4));
                        seq_ok = 1'b1;
                        foreach (obs_code_q[k]) begin
                            if (k == 0)          code = 5'b10000;
                            else if (k == 1)     code = 5'b01000;
                            else if (k < L + 2)  code = 5'b00100;
                            else if (k == L + 2) code = 5'b00010;
                            else                 code = 5'b00001;
                            if (obs_code_q[k] !== code) seq_ok = 1'b0;
                        end
                        check("strobe_seq", 64'(seq_ok), 1);
                        act_tdi = '0;
                        foreach (obs_tdi_q[k]) if (k < 64) act_tdi[k] = obs_tdi_q[k];
                        check("sdr_periods", 64'(obs_tdi_q.size()), 64'(L));
                        check("tdi_bits", act_tdi, 64'(tx) & ((64'd1 << L) - 64'd1));
                        check("ir_in", (obs_irin_q.size() == 1) ? 64'(obs_irin_q[0]) : 64'hdead,
                              64'(exp_cmdir_q.pop_front()));
                    end
                end else if (rsp_valid && pending && rsp_data !== cur) begin
                    stable_ok = 1'b0;
                end
                if (rsp_valid && pending && rsp_ready) begin
                    check("rsp_stable", 64'(stable_ok), 1);
                    hs_cyc = cyc + 1;
                    rsp_count++;
                    pending = 1'b0;
                end
            end
        end
    end

    initial begin : stimulus
        int total;
        int n;
        int base;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_ir     = '0;
        cmd_data   = '0;
        cmd_len    = '0;
        rsp_ready  = 1'b0;
        vji_ir_out = '0;
        total      = 0;

        // reset while idle, then release
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 64'(cmd_ready), 1);
        check("post_reset_outputs", all_outputs() & ~(64'd1 << 53), 0);

        // full-length loopback
        send(2'b01, 38'h2A_5A5A_A5A5, 6'd38, 0, '0, 2'b10);
        total++;
        wait_rsp(total);

        // short scan, tdo stuck high
        send(2'b11, 38'b10110, 6'd5, 1, '0, 2'b01);
        total++;
        wait_rsp(total);

        // length 0 and over-range both clamp to DR_W
        send(2'b10, DR_W'({$urandom, $urandom}), 6'd0, 2, {$urandom, $urandom}, 2'b11);
        total++;
        wait_rsp(total);
        send(2'b00, DR_W'({$urandom, $urandom}), 6'd45, 2, {$urandom, $urandom}, 2'b00);
        total++;
        wait_rsp(total);

        // consumer stalls; a new command waits for the response handshake
        hold_low = 1'b1;
        send(2'b01, DR_W'({$urandom, $urandom}), 6'd12, 2, {$urandom, $urandom}, 2'b10);
        n = 0;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        fork
            begin
                repeat (20) @(negedge clk);
                hold_low = 1'b0;
            end
            send(2'b10, DR_W'({$urandom, $urandom}), 6'd7, 0, '0, 2'b01);
        join
        check("accept_after_hs", 64'(last_acc_cyc - hs_cyc), 1);
        total += 2;
        wait_rsp(total);

        // reset mid-SDR aborts the scan with no response
        send(2'b11, DR_W'({$urandom, $urandom}), 6'd38, 0, '0, 2'b11);
        n = 0;
        while (sdr_rises < 10 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reached_sdr_bit10", 64'(sdr_rises), 10);
        #1 reset = 1'b1;
        #1;
        check("abort_outputs", all_outputs(), 0);
        exp_data_q.delete();
        exp_tx_q.delete();
        exp_irout_q.delete();
        exp_cmdir_q.delete();
        exp_len_q.delete();
        exp_acc_q.delete();
        repeat (3) @(negedge clk);
        check("ready_in_reset", 64'(cmd_ready), 0);
        reset = 1'b0;
        base = rsp_count;
        repeat (60) @(negedge clk);
        check("no_rsp_after_abort", 64'(rsp_count), 64'(base));
        send(2'b01, DR_W'({$urandom, $urandom}), 6'd20, 2, {$urandom, $urandom}, 2'b10);
        total++;
        wait_rsp(total);

        // randomized commands
        for (int i = 0; i < 12; i++) begin
            send(IR_W'($urandom), DR_W'({$urandom, $urandom}), 6'($urandom_range(0, 63)),
                 $urandom_range(0, 2), {$urandom, $urandom}, IR_W'($urandom));
            total++;
            wait_rsp(total);
        end

        repeat (5) @(negedge clk);
        check("strobe_and_tck_rules", 64'(viol), 0);
        check("scoreboard_drained", 64'(exp_data_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
